ipad_addr_gen: RTL and testbench

Address and handshake controller for one PE's input scratchpad (IPad, `IPadSize` = 12 entries, circular). It accepts incoming input pixels from the row-broadcast network and produces the `IPadAddr` write/read control that the IPad array consumes. It replays sliding filter windows of `ipad_size` = Pch×R entries to the MAC, then retires Pch×U entries per output pixel. It sits between the PE-column issue logic (`PEiss`) and the IPad/MAC datapath of a single PE.

---
 rtl/ipad_addr_gen_pkg.sv | 72 +++++++
 rtl/ipad_addr_gen_ptr_wrap.sv | 28 ++
 rtl/ipad_addr_gen.sv | 219 +++++++++++++++++++++
 tb/tb_ipad_addr_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ipad_addr_gen_pkg.sv
// Shared PE configuration, control types and IPad address-generator helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// PECfg     : layer configuration record and IPad geometry.
// PECtlCfg  : PE-column instruction, IPad FSM states and IPad control word.
// ipad_addr_gen_pkg : window-counter width and configuration helpers.

package PECfg;
  localparam int IPadSize   = 12;
  localparam int IPadAddrWd = 4;
  localparam int PConfDWd   = 4;
  localparam int TwWd       = 10;

  typedef struct packed {
    logic [PConfDWd-1:0]   Pch;
    logic [PConfDWd-1:0]   U;
    logic [PConfDWd-1:0]   R;
    logic [2*PConfDWd-1:0] ipad_size;  // Pch*R
    logic [TwWd-1:0]       Tw;         // windows per layer row
  } Conf;
endpackage

package PECtlCfg;
  import PECfg::*;

  localparam int InstDWd = 3;
  localparam int StepWd  = 2*PConfDWd;  // width of Pch*U

  typedef enum logic [InstDWd-1:0] {
    STALL = 3'd0,
    RESET = 3'd1,
    START = 3'd2,
    WORK  = 3'd3
  } PEiss;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    LOOP = 3'd2,
    OLAP = 3'd3,
    POP  = 3'd4
  } IPadState;

  typedef struct packed {
    logic [IPadAddrWd-1:0] raddr;
    logic [IPadAddrWd-1:0] waddr;
    logic                  read;
    logic                  write;
  } IPadAddr;
endpackage

package ipad_addr_gen_pkg;
  import PECfg::*;
  import PECtlCfg::*;

  localparam int WinWd = 10;

  // Entries retired per output pixel.
  function automatic logic [StepWd-1:0] conf_step(input Conf c);
    return StepWd'(c.Pch) * StepWd'(c.U);
  endfunction

  // A window that does not fit, an empty window, a retire step larger than
  // the window, or a zero window count cannot be run.
  function automatic logic conf_bad(input Conf c, input int padsz);
    logic [StepWd-1:0] st;
    st = conf_step(c);
    return (int'(c.ipad_size) > padsz) || (c.ipad_size == '0) ||
           (st > c.ipad_size) || (c.Tw == '0);
  endfunction
endpackage

// File: rtl/ipad_addr_gen_ptr_wrap.sv
// ipad_ptr_wrap: combinational (a+b) mod PADSZ for circular IPad pointers.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (AW bits, a < PADSZ, b <= PADSZ) -> y (AW bits).

module ipad_ptr_wrap
  import PECfg::*;
#(
  parameter int PADSZ = IPadSize,
  parameter int AW    = IPadAddrWd
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] y
);

  localparam logic [AW:0] PAD_W = (AW+1)'(PADSZ);

  logic [AW:0] sum;
  logic [AW:0] sum_wr;

  // One extra bit holds the carry; a single conditional subtract suffices
  // because both operands are bounded by PADSZ.
  assign sum    = {1'b0, a} + {1'b0, b};
  assign sum_wr = (sum >= PAD_W) ? (sum - PAD_W) : sum;
  assign y      = sum_wr[AW-1:0];

endmodule

// File: rtl/ipad_addr_gen.sv
// ipad_addr_gen: IPad write/read address + handshake control for one PE.
// Latency: START->first in_ready 1 cycle; last INIT write->first out_valid 2 cycles; 1 bubble per window.
// Backpressure: in_ready drops when the pad is full or on STALL; reads wait on out_ready and on unwritten data.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   iss               PEiss instruction (STALL/RESET/START/WORK)
//   conf              layer configuration (Pch, U, ipad_size, Tw used)
//   in_valid/in_ready incoming pixel handshake (write = in_valid & in_ready)
//   out_valid/out_ready MAC read handshake (read = out_valid & out_ready)
//   out_last          the current read is the last entry of its window
//   ipad              {raddr, waddr, read, write} to the IPad array
//   busy              FSM not IDLE
//   conf_err          last START refused (only with IPAD_CONF_CHK_EN)
// Build option: define IPAD_CONF_CHK_EN to reject illegal configurations at START.

module ipad_addr_gen
  import PECfg::*;
  import PECtlCfg::*;
  import ipad_addr_gen_pkg::*;
#(
  parameter int PADSZ = IPadSize,
  parameter int AW    = IPadAddrWd
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [InstDWd-1:0]         iss,
  input  logic [$bits(Conf)-1:0]     conf,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$bits(IPadAddr)-1:0] ipad,
  output logic                       busy,
  output logic                       conf_err
);

  localparam logic [AW-1:0] PAD_A = PADSZ[AW-1:0];

  Conf     cfg;
  PEiss    op;
  IPadAddr ia;

  IPadState         state, state_d;
  logic [AW-1:0]    wptr, wptr_d;
  logic [AW-1:0]    base, base_d;
  logic [AW-1:0]    rcnt, rcnt_d;
  logic [AW-1:0]    fill, fill_d;
  logic [WinWd-1:0] win, win_d;
  logic [StepWd-1:0] step, step_d;
  logic [StepWd-1:0] isz, isz_d;
  logic [TwWd-1:0]  tw, tw_d;

  logic          stall;
  logic          wr, rd;
  logic          rd_last;
  logic          start_ok;
  logic [AW-1:0] raddr, base_nxt, wptr_inc;
  logic [AW-1:0] fill_add;
  logic          unused_bits;

  assign cfg   = Conf'(conf);
  assign op    = PEiss'(iss);
  assign stall = (op == STALL);

  assign in_ready  = (state != IDLE) && (fill < PAD_A) && !stall;
  assign out_valid = (state == LOOP) && (rcnt < fill) && !stall;
  assign wr        = in_valid & in_ready;
  assign rd        = out_valid & out_ready;
  assign rd_last   = ({{(StepWd-AW){1'b0}}, rcnt} == (isz - StepWd'(1)));
  assign out_last  = rd & rd_last;
  assign busy      = (state != IDLE);
  assign fill_add  = fill + {{(AW-1){1'b0}}, wr};

  ipad_ptr_wrap #(.PADSZ(PADSZ), .AW(AW)) u_raddr (
    .a(base), .b(rcnt), .y(raddr)
  );
  ipad_ptr_wrap #(.PADSZ(PADSZ), .AW(AW)) u_base (
    .a(base), .b(step[AW-1:0]), .y(base_nxt)
  );
  ipad_ptr_wrap #(.PADSZ(PADSZ), .AW(AW)) u_wptr (
    .a(wptr), .b(AW'(1)), .y(wptr_inc)
  );

  // Pointers keep their last values in IDLE; the array must see zeros there.
  always_comb begin
    ia = '0;
    if (state != IDLE) begin
      ia.raddr = raddr;
      ia.waddr = wptr;
    end
    ia.read  = rd;
    ia.write = wr;
  end
  assign ipad = ia;

  // Only the window/step products matter; R is already folded into ipad_size.
  assign unused_bits = ^{cfg.R, step[StepWd-1:AW]};

`ifdef IPAD_CONF_CHK_EN
  logic conf_err_q, conf_err_d;
  assign conf_err = conf_err_q;
`else
  assign conf_err = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    wptr_d   = wptr;
    base_d   = base;
    rcnt_d   = rcnt;
    fill_d   = fill;
    win_d    = win;
    step_d   = step;
    isz_d    = isz;
    tw_d     = tw;
    start_ok = 1'b0;
`ifdef IPAD_CONF_CHK_EN
    conf_err_d = conf_err_q;
`endif

    if (wr) wptr_d = wptr_inc;

    case (state)
      IDLE: begin
        if (op == START) begin
`ifdef IPAD_CONF_CHK_EN
          if (conf_bad(cfg, PADSZ)) begin
            conf_err_d = 1'b1;
          end else begin
            conf_err_d = 1'b0;
            start_ok   = 1'b1;
          end
`else
          start_ok = 1'b1;
`endif
        end
        if (start_ok) begin
          step_d  = conf_step(cfg);
          isz_d   = cfg.ipad_size;
          tw_d    = cfg.Tw;
          wptr_d  = '0;
          base_d  = '0;
          rcnt_d  = '0;
          fill_d  = '0;
          win_d   = '0;
          state_d = INIT;
        end
      end
      INIT: begin
        fill_d = fill_add;
        // Registered fill: the window becomes readable one cycle after it fills.
        if ({{(StepWd-AW){1'b0}}, fill} >= isz) state_d = LOOP;
      end
      LOOP: begin
        fill_d = fill_add;
        if (rcnt >= fill) begin
          state_d = OLAP;
        end else if (rd) begin
          if (rd_last) begin
            rcnt_d  = '0;
            win_d   = win + WinWd'(1);
            state_d = POP;
          end else begin
            rcnt_d = rcnt + AW'(1);
          end
        end
      end
      OLAP: begin
        fill_d = fill_add;
        // Look at this cycle's write so reading resumes on the next cycle.
        if (rcnt < fill_add) state_d = LOOP;
      end
      POP: begin
        base_d = base_nxt;
        fill_d = fill_add - step[AW-1:0];
        if (win == tw) begin
          fill_d  = '0;
          state_d = IDLE;
        end else begin
          state_d = LOOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (op == RESET)) begin
      state <= IDLE;
      wptr  <= '0;
      base  <= '0;
      rcnt  <= '0;
      fill  <= '0;
      win   <= '0;
      step  <= '0;
      isz   <= '0;
      tw    <= '0;
`ifdef IPAD_CONF_CHK_EN
      conf_err_q <= 1'b0;
`endif
    end else if (!stall) begin
      state <= state_d;
      wptr  <= wptr_d;
      base  <= base_d;
      rcnt  <= rcnt_d;
      fill  <= fill_d;
      win   <= win_d;
      step  <= step_d;
      isz   <= isz_d;
      tw    <= tw_d;
`ifdef IPAD_CONF_CHK_EN
      conf_err_q <= conf_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ipad_addr_gen.sv
// Testbench for ipad_addr_gen: scenario table with a read-address scoreboard.
// Latency: checks first-read, resume and completion cycles per scenario.
// Backpressure: exercises full-pad write stall, OLAP starvation, STALL and RESET.

module tb_ipad_addr_gen;

  localparam logic [2:0] I_STALL = 3'd0;
  localparam logic [2:0] I_RESET = 3'd1;
  localparam logic [2:0] I_START = 3'd2;
  localparam logic [2:0] I_WORK  = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iss;
  logic [29:0] conf;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [9:0]  ipad;
  logic        busy, conf_err;

  always #5 clk = ~clk;

  ipad_addr_gen dut (
    .clk(clk), .rst(rst), .iss(iss), .conf(conf),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .ipad(ipad), .busy(busy), .conf_err(conf_err)
  );

  typedef struct {
    int pch, r, u, tw, npix;
    int hold_px;      // stop offering pixels after this many (-1: never)
    int release_cyc;  // cycle from which offering resumes
    int stall_cyc;    // first of 5 STALL cycles (-1: none)
    int reset_cyc;    // RESET issued in this cycle (-1: none)
    int chk_rd_idx;   // read index whose cycle is checked
    int chk_rd_cyc;
    int nordy_cyc;    // cycle where in_ready must be 0 despite pending pixels
    int done_cyc;     // first cycle busy=0 (-1: not checked)
  } scen_t;

  typedef struct packed {
    logic [3:0] raddr;
    logic       last;
  } exp_t;

  exp_t  sb[$];
  exp_t  e;
  scen_t tbl[6];
  scen_t s;
  int    checks = 0;
  int    passed = 0;
  int    sent, nrd, rd_seen, done, isz, step;
  logic  offer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [29:0] mk_conf(input int pch, input int u, input int r, input int tw);
    logic [3:0] p4, u4, r4;
    logic [7:0] i8;
    logic [9:0] t10;
    p4  = pch[3:0];
    u4  = u[3:0];
    r4  = r[3:0];
    i8  = 8'(pch * r);
    t10 = tw[9:0];
    return {p4, u4, r4, i8, t10};
  endfunction

  initial begin
    //          pch r u tw npix hold rel stall rst  idx cyc nordy done
    tbl[0] = '{1, 3, 1, 4, 6,  -1, 0,  -1,  -1,  0,  5,  -1,  21};  // plain stream
    tbl[1] = '{4, 3, 1, 3, 20, -1, 0,  -1,  -1,  0,  14, 13,  53};  // full pad, wrap
    tbl[2] = '{1, 3, 1, 4, 6,  3,  14, -1,  -1,  5,  15, -1,  25};  // OLAP starvation
    tbl[3] = '{1, 3, 1, 4, 6,  3,  8,  -1,  -1,  5,  11, -1,  21};  // write during POP
    tbl[4] = '{1, 3, 1, 4, 6,  -1, 0,  5,   -1,  0,  10, -1,  26};  // 5-cycle STALL
    tbl[5] = '{1, 3, 1, 4, 6,  -1, 0,  -1,  9,   2,  7,  -1,  10};  // RESET mid-LOOP

    rst = 1'b1; iss = I_WORK; conf = '0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ipad", ipad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conf_err", conf_err, 0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    for (int si = 0; si < 6; si++) begin
      s    = tbl[si];
      isz  = s.pch * s.r;
      step = s.pch * s.u;
      conf = mk_conf(s.pch, s.u, s.r, s.tw);
      sb.delete();
      for (int w = 0; w < s.tw; w++)
        for (int k = 0; k < isz; k++) begin
          e.raddr = 4'((w * step + k) % 12);
          e.last  = (k == isz - 1);
          sb.push_back(e);
        end
      sent = 0; nrd = 0; rd_seen = -1; done = -1;

      for (int cyc = 0; cyc < 400 && done < 0; cyc++) begin
        if (cyc == 0) iss = I_START;
        else if (s.stall_cyc >= 0 && cyc >= s.stall_cyc && cyc < s.stall_cyc + 5) iss = I_STALL;
        else if (cyc == s.reset_cyc) iss = I_RESET;
        else iss = I_WORK;
        offer = (sent < s.npix) && !(s.hold_px >= 0 && sent >= s.hold_px && cyc < s.release_cyc);
        in_valid  = offer;
        out_ready = (cyc != s.reset_cyc);
        #1;
        if (cyc > 0 && !busy) begin
          done = cyc;
          chk($sformatf("s%0d_idle_ipad", si), ipad, 0);
          chk($sformatf("s%0d_idle_out_valid", si), out_valid, 0);
          chk($sformatf("s%0d_idle_in_ready", si), in_ready, 0);
        end else begin
          if (cyc == 0) chk($sformatf("s%0d_start_in_ready", si), in_ready, 0);
          if (cyc == 1) chk($sformatf("s%0d_first_in_ready", si), in_ready, 1);
          if (cyc == s.nordy_cyc) chk($sformatf("s%0d_full_in_ready", si), {in_valid, in_ready}, 2'b10);
          if (s.stall_cyc >= 0 && cyc >= s.stall_cyc && cyc < s.stall_cyc + 5)
            chk($sformatf("s%0d_stall_c%0d", si, cyc), {ipad[1], ipad[0], in_ready, out_valid}, 0);
          if (ipad[0]) begin
            chk($sformatf("s%0d_waddr%0d", si, sent), ipad[5:2], (sent % 12));
            sent++;
          end
          if (ipad[1]) begin
            if (sb.size() == 0) begin
              chk($sformatf("s%0d_extra_read", si), 1, 0);
            end else begin
              e = sb.pop_front();
              chk($sformatf("s%0d_raddr%0d", si, nrd), ipad[9:6], e.raddr);
              chk($sformatf("s%0d_last%0d", si, nrd), out_last, e.last);
            end
            if (nrd == s.chk_rd_idx) rd_seen = cyc;
            nrd++;
          end
        end
        @(posedge clk); #1;
      end

      if (done < 0) chk($sformatf("s%0d_timeout", si), 0, 1);
      if (s.reset_cyc < 0) chk($sformatf("s%0d_reads_left", si), sb.size(), 0);
      sb.delete();
      chk($sformatf("s%0d_writes", si), sent, s.npix);
      chk($sformatf("s%0d_rd%0d_cycle", si, s.chk_rd_idx), rd_seen, s.chk_rd_cyc);
      if (s.done_cyc >= 0) chk($sformatf("s%0d_done_cycle", si), done, s.done_cyc);
    end

`ifdef IPAD_CONF_CHK_EN
    in_valid = 1'b0;
    iss  = I_START;
    conf = mk_conf(4, 1, 4, 3);
    @(posedge clk); #1;
    iss = I_WORK;
    #1;
    chk("bad_conf_err", conf_err, 1);
    chk("bad_conf_busy", busy, 0);
    iss  = I_START;
    conf = mk_conf(1, 1, 3, 4);
    @(posedge clk); #1;
    iss = I_WORK;
    #1;
    chk("good_conf_err", conf_err, 0);
    chk("good_conf_busy", busy, 1);
    iss = I_RESET;
    @(posedge clk); #1;
    iss = I_WORK;
    #1;
    chk("conf_reset_busy", busy, 0);
`else
    chk("conf_err_tied", conf_err, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
